reg_block_xfer_seq: RTL and testbench

REG_BLOCK_XFER_SEQ -- requirements
Module: reg_block_xfer_seq

---
 rtl/arm_sim_pkg.sv | 24 ++
 rtl/priority_enc_16x4.sv | 20 ++
 rtl/reg_block_xfer_seq.sv | 172 +++++++++++++++++
 tb/tb_reg_block_xfer_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_sim_pkg.sv
// Shared types and constants for the block-transfer sequencer: state encoding,
// default word stride, register-file read/write codes and a popcount helper.
package arm_sim_pkg;

  localparam int   WORD_BYTES_DEF = 4;
  localparam logic RF_READ        = 1'b1;
  localparam logic RF_WRITE       = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    ACCESS = 3'd2,
    WBACK  = 3'd3,
    DONE   = 3'd4
  } xfer_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/priority_enc_16x4.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set request bit.
module priority_enc_16x4 (
  input  logic [15:0] i_req,
  output logic [3:0]  o_idx,
  output logic        o_valid
);

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_block_xfer_seq.sv
// Block register transfer sequencer (LDM/STM style), one register per memory access.
// Base write-back is built only when REG_BLOCK_XFER_WRITEBACK_EN is defined.
module reg_block_xfer_seq
  import arm_sim_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        start,
  input  logic        load,
  input  logic        up,
  input  logic        pre,
  input  logic        writeBack,
  input  logic [3:0]  baseReg,
  input  logic [15:0] regList,
  input  logic [31:0] baseValue,
  input  logic [31:0] rfData,
  input  logic        memDone,
  input  logic [31:0] memRdData,
  output logic [3:0]  rfAddrB,
  output logic [3:0]  rfWriteAddr,
  output logic [31:0] rfWriteData,
  output logic        rfRW,
  output logic [31:0] memAddr,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memWrData,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbgState
);

  localparam logic [31:0] L_STRIDE = 32'(WORD_BYTES);

  xfer_state_t r_state;
  logic        r_load;
  logic [15:0] r_list;
  logic [31:0] r_addr;
  logic [3:0]  r_cur;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_done;

  logic [4:0]  w_n;
  logic [31:0] w_span;
  logic [31:0] w_start_addr;
  logic [3:0]  w_pe_idx;
  logic        w_pe_valid;
  logic        w_ld_wr;
  logic        w_wb_wr;

  assign w_n    = popcount16(regList);
  assign w_span = 32'(w_n) * L_STRIDE;
  // Lowest register always sits at the lowest address, whatever the direction.
  assign w_start_addr = up ? baseValue + (pre ? L_STRIDE : 32'd0)
                           : baseValue - w_span + (pre ? 32'd0 : L_STRIDE);

`ifdef REG_BLOCK_XFER_WRITEBACK_EN
  logic        r_wb_cond;
  logic [3:0]  r_base_reg;
  logic [31:0] r_wb_val;
  logic        w_wb_cond;
  assign w_wb_cond = writeBack && (w_n != 5'd0) && !(load && regList[baseReg]);
  assign w_wb_wr   = (r_state == WBACK);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{writeBack, baseReg};
  assign w_wb_wr      = 1'b0;
`endif

  priority_enc_16x4 u_pe (
    .i_req   (r_list),
    .o_idx   (w_pe_idx),
    .o_valid (w_pe_valid)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state     <= IDLE;
      r_load      <= 1'b0;
      r_list      <= '0;
      r_addr      <= '0;
      r_cur       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
`ifdef REG_BLOCK_XFER_WRITEBACK_EN
      r_wb_cond   <= 1'b0;
      r_base_reg  <= '0;
      r_wb_val    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_load  <= load;
            r_list  <= regList;
            r_addr  <= w_start_addr;
            r_state <= SCAN;
`ifdef REG_BLOCK_XFER_WRITEBACK_EN
            r_wb_cond  <= w_wb_cond;
            r_base_reg <= baseReg;
            r_wb_val   <= up ? baseValue + w_span : baseValue - w_span;
`endif
          end
        end
        SCAN: begin
          if (w_pe_valid) begin
            r_cur       <= w_pe_idx;
            r_mem_read  <= r_load;
            r_mem_write <= !r_load;
            r_state     <= ACCESS;
`ifdef REG_BLOCK_XFER_WRITEBACK_EN
          end else if (r_wb_cond) begin
            r_state <= WBACK;
`endif
          end else begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        ACCESS: begin
          if (memDone) begin
            r_list      <= r_list & ~(16'd1 << r_cur);
            r_addr      <= r_addr + L_STRIDE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= SCAN;
          end
        end
`ifdef REG_BLOCK_XFER_WRITEBACK_EN
        WBACK: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Register writes last exactly the memDone cycle (load) or the WBACK cycle.
  assign w_ld_wr = (r_state == ACCESS) && r_load && memDone;

  always_comb begin
    rfWriteAddr = '0;
    rfWriteData = '0;
    if (w_ld_wr) begin
      rfWriteAddr = r_cur;
      rfWriteData = memRdData;
`ifdef REG_BLOCK_XFER_WRITEBACK_EN
    end else if (w_wb_wr) begin
      rfWriteAddr = r_base_reg;
      rfWriteData = r_wb_val;
`endif
    end
  end

  assign rfRW      = (w_ld_wr || w_wb_wr) ? RF_WRITE : RF_READ;
  assign rfAddrB   = r_cur;
  assign memAddr   = r_addr;
  assign memRead   = r_mem_read;
  assign memWrite  = r_mem_write;
  assign memWrData = r_mem_write ? rfData : 32'd0;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dbgState  = r_state;

endmodule

// File: tb/tb_reg_block_xfer_seq.sv
// Randomized bench for reg_block_xfer_seq: a transfer-level model predicts the ordered
// memory accesses and register writes, which a monitor compares as they happen.
module tb_reg_block_xfer_seq;

  localparam int WB = 4;
  localparam int W  = 67;
`ifdef REG_BLOCK_XFER_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        start = 1'b0, load = 1'b0, up = 1'b0, pre = 1'b0, writeBack = 1'b0;
  logic [3:0]  baseReg = '0;
  logic [15:0] regList = '0;
  logic [31:0] baseValue = '0;
  logic [31:0] rfData;
  logic        memDone = 1'b0;
  logic [31:0] memRdData = '0;
  logic [3:0]  rfAddrB, rfWriteAddr;
  logic [31:0] rfWriteData, memAddr, memWrData;
  logic        rfRW, memRead, memWrite, busy, done;
  logic [2:0]  dbgState;

  logic [31:0]  rf [16];
  logic [31:0]  salt = '0;
  int           lat_cfg = 0;
  bit           spurious_en = 1'b0;
  int           req_age = 0;
  int           ev_seen = 0;
  int           done_cnt = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];

  reg_block_xfer_seq dut (
    .CLK(CLK), .CLR(CLR), .start(start), .load(load), .up(up), .pre(pre),
    .writeBack(writeBack), .baseReg(baseReg), .regList(regList), .baseValue(baseValue),
    .rfData(rfData), .memDone(memDone), .memRdData(memRdData), .rfAddrB(rfAddrB),
    .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData), .rfRW(rfRW), .memAddr(memAddr),
    .memRead(memRead), .memWrite(memWrite), .memWrData(memWrData), .busy(busy),
    .done(done), .dbgState(dbgState)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb rfData = rf[rfAddrB];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Event encoding: {reg_write, mem_write, mem_read, addr[31:0], data[31:0]}.
  task automatic observe(input logic [W-1:0] ev);
    ev_seen++;
    if (exp_q.size() == 0) check("unexpected_event", ev, W'(0));
    else check("event", ev, exp_q.pop_front());
  endtask

  // ---------------- memory responder ----------------
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (memRead || memWrite) begin
        memDone   = (req_age >= lat_cfg);
        memRdData = memDone ? mem_val(memAddr) : 32'h0;
        req_age++;
      end else begin
        req_age   = 0;
        memDone   = spurious_en && ($urandom_range(0, 2) == 0);
        memRdData = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge CLK);
      if (CLR) begin
        if (memDone && (memRead || memWrite))
          observe({1'b0, memWrite, memRead, memAddr, memWrite ? memWrData : 32'h0});
        if (rfRW == 1'b0) begin
          observe({3'b100, 28'h0, rfWriteAddr, rfWriteData});
          rf[rfWriteAddr] = rfWriteData;
        end
        if (done) done_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic expect_xfer(input bit ld, input bit u, input bit p, input bit wbk,
                             input logic [3:0] br, input logic [15:0] lst,
                             input logic [31:0] base, input int lat, output int exp_cyc);
    int          n;
    bit          wb;
    logic [31:0] a, span;
    n    = $countones(lst);
    span = 32'(n * WB);
    a    = u ? base + (p ? 32'(WB) : 32'd0) : base - span + (p ? 32'd0 : 32'(WB));
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        if (ld) begin
          exp_q.push_back({3'b001, a, 32'h0});
          exp_q.push_back({3'b100, 28'h0, 4'(i), mem_val(a)});
        end else begin
          exp_q.push_back({3'b010, a, rf[i]});
        end
        a = a + 32'(WB);
      end
    end
    wb = WB_EN && wbk && (n > 0) && !(ld && lst[br]);
    if (wb) exp_q.push_back({3'b100, 28'h0, br, u ? base + span : base - span});
    // start cycle + final SCAN, plus per register one SCAN and lat+1 ACCESS cycles
    exp_cyc = 2 + n * (lat + 2) + (wb ? 1 : 0);
  endtask

  // ---------------- driver ----------------
  task automatic drive_start(input bit ld, input bit u, input bit p, input bit wbk,
                             input logic [3:0] br, input logic [15:0] lst, input logic [31:0] base);
    @(posedge CLK); #1;
    load = ld; up = u; pre = p; writeBack = wbk;
    baseReg = br; regList = lst; baseValue = base; start = 1'b1;
  endtask

  task automatic run_xfer(input bit ld, input bit u, input bit p, input bit wbk,
                          input logic [3:0] br, input logic [15:0] lst, input logic [31:0] base,
                          input int lat, input bit spur, input bit second_start);
    int exp_cyc, cyc, done0;
    bit seen;
    salt        = $urandom;
    lat_cfg     = lat;
    spurious_en = spur;
    expect_xfer(ld, u, p, wbk, br, lst, base, lat, exp_cyc);
    done0 = done_cnt;
    drive_start(ld, u, p, wbk, br, lst, base);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
      else begin
        cyc++;
        @(posedge CLK); #1;
        start = second_start && (cyc == 2);
        if (start) begin
          load = $urandom; regList = $urandom; baseValue = $urandom; baseReg = $urandom;
        end
      end
    end
    start = 1'b0;
    check("done_seen", W'(seen), W'(1));
    if (seen) check("done_latency", W'(cyc), W'(exp_cyc));
    repeat (3) @(negedge CLK);
    check("done_pulses", W'(done_cnt - done0), W'(1));
    check("exp_drained", W'(exp_q.size()), W'(0));
    check("idle_busy", W'(busy), W'(0));
    exp_q.delete();
    spurious_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          k, ev0, dummy;
    bit          ld;
    logic [15:0] lst;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;

    #2;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_memRead", W'(memRead), W'(0));
    check("rst_memWrite", W'(memWrite), W'(0));
    check("rst_rfRW", W'(rfRW), W'(1));
    check("rst_memAddr", W'(memAddr), W'(0));
    check("rst_memWrData", W'(memWrData), W'(0));
    check("rst_rfAddrB", W'(rfAddrB), W'(0));
    check("rst_rfWriteAddr", W'(rfWriteAddr), W'(0));
    check("rst_rfWriteData", W'(rfWriteData), W'(0));
    @(negedge CLK); #2 CLR = 1'b1;

    run_xfer(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'h000B, 32'h0000_0100, 1, 1'b0, 1'b0);
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 16'h00F0, 32'h0000_0200, 3, 1'b0, 1'b0);
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4'd2,  16'h0000, 32'h0000_0300, 1, 1'b1, 1'b0);
    run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  16'h0003, 32'h0000_0500, 0, 1'b0, 1'b0);
    run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 16'h8001, 32'hFFFF_FFF8, 2, 1'b1, 1'b1);

    // Clear during the second access of a four-register store.
    salt    = $urandom;
    lat_cfg = 2;
    expect_xfer(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h1111, 32'h0000_0400, 2, dummy);
    ev0 = ev_seen;
    drive_start(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h1111, 32'h0000_0400);
    @(posedge CLK); #1 start = 1'b0;
    k = 0;
    while (!(ev_seen == ev0 + 1 && memWrite && !memDone) && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("clr_at_second_access", W'(ev_seen - ev0), W'(1));
    #2 CLR = 1'b0;
    #1;
    check("clr_busy", W'(busy), W'(0));
    check("clr_memWrite", W'(memWrite), W'(0));
    check("clr_memRead", W'(memRead), W'(0));
    check("clr_rfRW", W'(rfRW), W'(1));
    check("clr_memAddr", W'(memAddr), W'(0));
    exp_q.delete();
    repeat (3) @(negedge CLK);
    #2 CLR = 1'b1;
    repeat (2) @(negedge CLK);
    check("clr_no_resume", W'(busy), W'(0));
    run_xfer(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h1111, 32'h0000_0400, 2, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ld = $urandom;
      case ($urandom_range(0, 7))
        0:       lst = 16'h0000;
        1:       lst = 16'hFFFF;
        default: lst = $urandom;
      endcase
      run_xfer(ld, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), lst, $urandom,
               $urandom_range(0, 3), 1'($urandom), (lst != 16'h0) && ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
